// File: rtl/rtlola_pkg.sv
// Shared definitions for the RTLola input event queue.
//   NUM_INPUTS / DATA_W / TAG_W : lane count, lane width and timestamp width.
//                                 They fix the layout of rtlola_event_t, so
//                                 change them here rather than per instance.
//   rtlola_event_t              : one buffered event {data, new_mask, tag}.
//   lane_mask()                 : zeroes every lane whose new-value bit is 0.
package rtlola_pkg;

    localparam int NUM_INPUTS = 2;
    localparam int DATA_W     = 64;
    localparam int TAG_W      = 64;

    typedef logic [NUM_INPUTS-1:0][DATA_W-1:0] lanes_t;

    typedef struct packed {
        lanes_t                  data;
        logic [NUM_INPUTS-1:0]   new_mask;
        logic [TAG_W-1:0]        tag;
    } rtlola_event_t;

    // Lanes without a fresh value carry stale data upstream; they are stored
    // as 0 so the monitor never sees a value it was not told about.
    function automatic lanes_t lane_mask(input lanes_t data,
                                         input logic [NUM_INPUTS-1:0] new_mask);
        lanes_t result;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            result[i] = new_mask[i] ? data[i] : '0;
        end
        return result;
    endfunction

endpackage

// File: rtl/rtlola_event_fifo_mem.sv
// Event storage for the queue: DEPTH entries of rtlola_event_t.
//   clk     : write clock
//   wr_en   : write wr_data into entry wr_ptr on the rising edge
//   wr_ptr  : write address
//   wr_data : event to store
//   rd_ptr  : read address
//   rd_data : entry at rd_ptr, combinational read
// The array carries no reset; validity is tracked by the occupancy count in
// the parent, which also gates the outputs.
module rtlola_event_fifo_mem
    import rtlola_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [PTR_W-1:0]     wr_ptr,
    input  rtlola_event_t        wr_data,
    input  logic [PTR_W-1:0]     rd_ptr,
    output rtlola_event_t        rd_data
);

    rtlola_event_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/rtlola_event_queue.sv
// Input stage in front of the RTLola monitor. Each clock edge with en=1 and at
// least one new-value strobe captures an event {masked lane data, strobes,
// timestamp} into a FIFO; the monitor dequeues the head with pop.
//   clk, rst  : clock (rising edge), asynchronous active-low reset
//   en        : global enable; with en=0 every register holds
//   in_data   : lane i at [i*DATA_W +: DATA_W]
//   in_new    : per-lane new-value strobes
//   pop       : dequeue request from the monitor
//   out_valid : FIFO non-empty; out_data/out_new/out_tag are the head entry,
//               forced to 0 when empty
//   count     : occupancy 0..DEPTH
//   overflow  : sticky, set when an event was dropped on a full FIFO
//   drop_cnt  : saturating count of dropped events
module rtlola_event_queue
    import rtlola_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]        in_new,
    input  logic                         pop,
    output logic                         out_valid,
    output logic [NUM_INPUTS*DATA_W-1:0] out_data,
    output logic [NUM_INPUTS-1:0]        out_new,
    output logic [TAG_W-1:0]             out_tag,
    output logic [CNT_W-1:0]             count,
    output logic                         overflow,
    output logic [DROP_W-1:0]            drop_cnt
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TAG_W-1:0]  time_cnt_q, time_cnt_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    lanes_t            in_lanes;
    rtlola_event_t     wr_entry;
    rtlola_event_t     head;
    logic              non_empty;
    logic              full;
    logic              is_event;
    logic              pop_eff;
    logic              push_ok;
    logic              drop;

    assign in_lanes = in_data;

    always_comb begin
        non_empty = (count_q != '0);
        full      = (count_q == CNT_W'(DEPTH));
        is_event  = en & (|in_new);
        pop_eff   = en & pop & non_empty;
        // A full FIFO still accepts an event when the head leaves on the same edge.
        push_ok   = is_event & (~full | pop_eff);
        drop      = is_event & ~push_ok;

        // Tag is the counter value before this edge's increment.
        wr_entry.data     = lane_mask(in_lanes, in_new);
        wr_entry.new_mask = in_new;
        wr_entry.tag      = time_cnt_q;

        time_cnt_d = en ? time_cnt_q + TAG_W'(1) : time_cnt_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_eff);
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop_eff);
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            time_cnt_q <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            time_cnt_q <= time_cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    rtlola_event_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok),
        .wr_ptr  (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr_q),
        .rd_data (head)
    );

    // Storage is unreset, so the head is only exposed while the count says it
    // holds a real entry; this also makes every output 0 during reset.
    generate
        for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_out_lane
            assign out_data[gi*DATA_W +: DATA_W] = non_empty ? head.data[gi] : '0;
        end
    endgenerate

    assign out_valid = non_empty;
    assign out_new   = non_empty ? head.new_mask : '0;
    assign out_tag   = non_empty ? head.tag : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
